// File: rtl/rf_seq_pkg.sv
// Shared types and default sizes for the register-file operation sequencer.
package rf_seq_pkg;
  localparam int RF_WIDTH  = 4;
  localparam int RF_ADDR_W = 2;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_LDI} op_t;
  typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, LOAD} state_t;
endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU: WIDTH-bit ADD/SUB/AND evaluated in WIDTH+1 bits for carry/borrow.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);
  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum    = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum    = {1'b0, i_opa} + {1'b0, i_opb};
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      // Top bit of the widened difference is the unsigned borrow.
      OP_SUB: begin
        w_sum    = {1'b0, i_opa} - {1'b0, i_opb};
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      OP_AND:  o_result = i_opa & i_opb;
      default: ;
    endcase
  end
endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one operation at a time through a single-read-port register file:
// read A, read B, write result (or a single write for load-immediate).
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] op_dst,
  input  logic [ADDR_W-1:0] op_src_a,
  input  logic [ADDR_W-1:0] op_src_b,
  input  logic [WIDTH-1:0]  op_imm,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [WIDTH-1:0]  rf_rdata,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic              rf_we,
  output logic              res_valid,
  output logic              res_carry
);
  state_t            r_state, w_next;
  op_t               r_op;
  logic [ADDR_W-1:0] r_dst, r_src_a, r_src_b;
  logic [WIDTH-1:0]  r_imm, r_opa, r_opb;
  logic [WIDTH-1:0]  w_result;
  logic              w_carry;
  logic              w_accept;

  assign w_accept = (r_state == IDLE) && op_valid;

  rf_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .i_opa    (r_opa),
    .i_opb    (r_opb),
    .i_op     (r_op),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operation fields are only sampled on accept; operands as their read states pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_ADD;
      r_dst   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_imm   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op_t'(op_code);
        r_dst   <= op_dst;
        r_src_a <= op_src_a;
        r_src_b <= op_src_b;
        r_imm   <= op_imm;
      end
      if (r_state == READ_A) r_opa <= rf_rdata;
      if (r_state == READ_B) r_opb <= rf_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (op_valid) w_next = (op_t'(op_code) == OP_LDI) ? LOAD : READ_A;
      READ_A:  w_next = READ_B;
      READ_B:  w_next = WRITE;
      WRITE:   w_next = IDLE;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = 1'b0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    res_valid = 1'b0;
    res_carry = 1'b0;
    case (r_state)
      IDLE:   op_ready = 1'b1;
      READ_A: rf_raddr = r_src_a;
      READ_B: rf_raddr = r_src_b;
      WRITE: begin
        rf_we     = 1'b1;
        rf_waddr  = r_dst;
        rf_wdata  = w_result;
        res_valid = 1'b1;
        res_carry = w_carry;
      end
      LOAD: begin
        rf_we     = 1'b1;
        rf_waddr  = r_dst;
        rf_wdata  = r_imm;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 4-entry register file.
module tb_rf_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [1:0] op_dst, op_src_a, op_src_b;
  logic [3:0] op_imm;
  logic [1:0] rf_raddr, rf_waddr;
  logic [3:0] rf_rdata, rf_wdata;
  logic       rf_we, res_valid, res_carry;

  logic [3:0] rf [4] = '{default: 4'h0};
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_we    = 0;
  int acc_log [64];

  localparam logic [1:0] C_ADD = 2'b00, C_SUB = 2'b01, C_AND = 2'b10, C_LDI = 2'b11;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_dst(op_dst), .op_src_a(op_src_a), .op_src_b(op_src_b),
    .op_imm(op_imm), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_we(rf_we), .res_valid(res_valid), .res_carry(res_carry)
  );

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

  always @(posedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (n_acc < 64) acc_log[n_acc] = cyc;
      n_acc = n_acc + 1;
    end
    if (rf_we) n_we = n_we + 1;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and pass its accept edge; leaves op_valid low afterwards.
  task automatic issue(input logic [1:0] code, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [3:0] imm);
    op_code = code; op_dst = d; op_src_a = a; op_src_b = b; op_imm = imm;
    op_valid = 1'b1;
    chk("ready_before_accept", int'(op_ready), 1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input int wa, input int wd, input int cy);
    chk({tag, "_we"},    int'(rf_we),     1);
    chk({tag, "_rv"},    int'(res_valid), 1);
    chk({tag, "_waddr"}, int'(rf_waddr),  wa);
    chk({tag, "_wdata"}, int'(rf_wdata),  wd);
    chk({tag, "_carry"}, int'(res_carry), cy);
    chk({tag, "_busy"},  int'(op_ready),  0);
  endtask

  initial begin
    int base, acc0, we0;
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0;
    op_dst = '0; op_src_a = '0; op_src_b = '0; op_imm = '0;
    repeat (2) tick();
    chk("rst_ready", int'(op_ready), 1);
    chk("rst_we",    int'(rf_we), 0);
    chk("rst_rv",    int'(res_valid), 0);
    chk("rst_raddr", int'(rf_raddr), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", int'(op_ready), 1);
    chk("idle_we",    int'(rf_we), 0);
    for (int i = 0; i < 4; i++) chk("rf_init", int'(rf[i]), 0);

    // Two load-immediates
    issue(C_LDI, 2'd1, 2'd0, 2'd0, 4'h9);
    chk_write("ldi1", 1, 4'h9, 0);
    tick();
    chk("ldi1_ready", int'(op_ready), 1);
    chk("ldi1_we0",   int'(rf_we), 0);
    chk("rf1_9",      int'(rf[1]), 4'h9);
    issue(C_LDI, 2'd2, 2'd3, 2'd3, 4'h8);
    chk_write("ldi2", 2, 4'h8, 0);
    tick();
    chk("rf2_8", int'(rf[2]), 4'h8);

    // ADD r3 = r1 + r2 = 9 + 8 -> 1, carry
    issue(C_ADD, 2'd3, 2'd1, 2'd2, 4'h0);
    chk("add_ra",  int'(rf_raddr), 1);
    chk("add_we0", int'(rf_we), 0);
    tick();
    chk("add_rb",  int'(rf_raddr), 2);
    chk("add_we1", int'(rf_we), 0);
    tick();
    chk_write("add", 3, 4'h1, 1);
    tick();
    chk("add_ready", int'(op_ready), 1);
    chk("rf3_1",     int'(rf[3]), 4'h1);

    // SUB r1 = r2 - r1 = 8 - 9 -> F, borrow (dst aliases a source)
    issue(C_SUB, 2'd1, 2'd2, 2'd1, 4'h0);
    tick(); tick();
    chk_write("sub", 1, 4'hF, 1);
    tick();
    // AND r0 = r1 & r3 = F & 1 -> 1
    issue(C_AND, 2'd0, 2'd1, 2'd3, 4'h0);
    tick(); tick();
    chk_write("and", 0, 4'h1, 0);
    tick();
    chk("rf0_1", int'(rf[0]), 4'h1);

    // Back-to-back with op_valid held: ADD r2=r0+r3 (2), LDI r1=5, ADD r3=r2+r1 (7)
    acc0 = n_acc; we0 = n_we; base = cyc;
    op_code = C_ADD; op_dst = 2'd2; op_src_a = 2'd0; op_src_b = 2'd3; op_imm = 4'h0;
    op_valid = 1'b1;
    tick();
    op_code = C_LDI; op_dst = 2'd1; op_imm = 4'h5;
    repeat (4) tick();
    op_code = C_ADD; op_dst = 2'd3; op_src_a = 2'd2; op_src_b = 2'd1; op_imm = 4'h0;
    repeat (2) tick();
    op_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_nacc", n_acc - acc0, 3);
    chk("b2b_nwe",  n_we - we0, 3);
    chk("b2b_acc0", acc_log[acc0] - base, 0);
    chk("b2b_acc1", acc_log[acc0 + 1] - base, 4);
    chk("b2b_acc2", acc_log[acc0 + 2] - base, 6);
    chk("b2b_rf2",  int'(rf[2]), 4'h2);
    chk("b2b_rf1",  int'(rf[1]), 4'h5);
    chk("b2b_rf3",  int'(rf[3]), 4'h7);

    // Reset during READ_B of ADD r0 = r1 + r2: write must be abandoned
    we0 = n_we;
    issue(C_ADD, 2'd0, 2'd1, 2'd2, 4'h0);
    tick();
    chk("rst_mid_rb", int'(rf_raddr), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we",    int'(rf_we), 0);
    chk("rst_mid_rv",    int'(res_valid), 0);
    chk("rst_mid_ready", int'(op_ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("rst_rel_ready", int'(op_ready), 1);
    chk("rst_rel_nwe",   n_we - we0, 0);
    chk("rst_rel_rf0",   int'(rf[0]), 4'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Upstream controller for the 4-entry register file.
- Accepts one 3-address operation at a time over a valid/ready handshake and performs it in three steps: it reads operand A and then operand B through the file's single combinational read port, then writes the ALU result back.
- Also supports a load-immediate op that writes directly, so a bench or higher-level sequencer can initialise registers.

Parameters:
- WIDTH, 4, data width of register-file entries, immediates and results.
- ADDR_W, 2, register address width (2**ADDR_W registers).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request valid.
- op_ready  out  1  sequencer can accept an operation (high only in IDLE).
- op_code  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 LDI.
- op_dst  in  ADDR_W  destination register.
- op_src_a  in  ADDR_W  source register A (ignored for LDI).
- op_src_b  in  ADDR_W  source register B (ignored for LDI).
- op_imm  in  WIDTH  immediate value (LDI only).
- rf_raddr  out  ADDR_W  register-file read address.
- rf_rdata  in  WIDTH  register-file read data, combinational from rf_raddr.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  WIDTH  register-file write data.
- rf_we  out  1  write strobe; the register file instance gates its write on this.
- res_valid  out  1  one-cycle pulse coinciding with the write.
- res_carry  out  1  ADD carry-out or SUB borrow; 0 for AND and LDI; valid with res_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; op_ready=1; all other outputs 0; captured op fields and operand registers 0.
- All outputs are registered or decoded from the state register only; no combinational path from op_* inputs to outputs.
- IDLE:
  - op_ready=1 and rf_raddr=0.
  - On op_valid=1, latch op_code/dst/src_a/src_b/imm.
  - Next state is LOAD for LDI, otherwise READ_A.
- READ_A: rf_raddr=src_a; at the clock edge, capture rf_rdata into opA; next state READ_B.
- READ_B: rf_raddr=src_b; capture rf_rdata into opB; next state WRITE.
- LOAD: same outputs as WRITE, with rf_wdata=imm and res_carry=0; next state IDLE.
- WRITE: rf_we=1, rf_waddr=dst, rf_wdata=result, res_valid=1, res_carry as defined; next state IDLE.
- op_ready=0 in every state other than IDLE.
- Arithmetic:
  - All operations are WIDTH bits, modulo 2**WIDTH, computed in WIDTH+1 bits.
  - ADD: carry = bit WIDTH of opA+opB.
  - SUB: borrow = (opA < opB), unsigned.
  - AND: bitwise opA & opB.
- Latency, measured from the accept edge:
  - ALU ops: write on the 3rd cycle after accept; 4-cycle throughput.
  - LDI: write on the 1st cycle after accept; 2-cycle throughput.
- Back-to-back: op_valid held high is accepted again in the first IDLE cycle after WRITE/LOAD; no op is lost or duplicated.
- Hazards:
  - dst equal to src_a or src_b is legal, since both reads complete before the write.
  - src_a==src_b is legal.
  - An op issued after a write reads the new value, because the write lands before the next accept.
- op_* inputs are only sampled on the accept edge; changes while busy are ignored.
- Reset mid-operation: return to IDLE at once; the pending write is abandoned; rf_we and res_valid are 0 from reset assertion onward.
- Unknown op_code cannot occur because the 2-bit encoding is full.

Decomposition:
- Package rf_seq_pkg holds:
  - typedef enum op_t {OP_ADD, OP_SUB, OP_AND, OP_LDI};
  - typedef enum state_t {IDLE, READ_A, READ_B, WRITE, LOAD};
  - localparam defaults for WIDTH and ADDR_W.
- One combinational sub-module, rf_seq_alu: inputs opA, opB, op; outputs result and carry.
- The FSM and capture registers stay in the top module.

Test Plan:
- Reset then idle -> op_ready=1, rf_we=0, res_valid=0, rf_raddr=0; bench register file all zeros.
- LDI dst=1 imm=4'h9, then LDI dst=2 imm=4'h8 -> rf_we pulses one cycle after each accept with waddr=1/wdata=9, then waddr=2/wdata=8; op_ready returns high in between.
- ADD dst=3 a=1 b=2 (9+8) -> rf_raddr sequence 1,2; write on the 3rd cycle with waddr=3, wdata=4'h1, res_carry=1.
- SUB dst=1 a=2 b=1 (8-9), dst aliasing a source -> wdata=4'hF, res_carry=1; a subsequent AND dst=0 a=1 b=3 (F&1) writes 4'h1 with res_carry=0.
- op_valid held high for ADD, LDI, ADD back to back -> accepts exactly at cycles 0, 4 and 6; exactly three rf_we pulses.
- rst_n asserted during READ_B of an ADD -> no write occurs; after release: IDLE, op_ready=1, and the target register keeps its old value.
